id_ex_operand_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fwd_mux.sv | 41 ++++
 rtl/id_ex_operand_stage.sv | 161 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU control codes and the forward-select encoding.
// Consumed by id_ex_operand_stage and fwd_mux.
package cpu_pkg;

  localparam int CPU_DW = 32;
  localparam int CPU_AW = 5;
  localparam int CPU_CW = 4;

  localparam logic [CPU_CW-1:0] ALU_ADD  = 4'd0;
  localparam logic [CPU_CW-1:0] ALU_SUB  = 4'd1;
  localparam logic [CPU_CW-1:0] ALU_AND  = 4'd2;
  localparam logic [CPU_CW-1:0] ALU_OR   = 4'd3;
  localparam logic [CPU_CW-1:0] ALU_SLT  = 4'd4;
  localparam logic [CPU_CW-1:0] ALU_SLTU = 4'd5;
  localparam logic [CPU_CW-1:0] ALU_SLLV = 4'd6;
  localparam logic [CPU_CW-1:0] ALU_LUI  = 4'd7;
  localparam logic [CPU_CW-1:0] ALU_ORI  = 4'd8;
  localparam logic [CPU_CW-1:0] ALU_BEQ  = 4'd9;
  localparam logic [CPU_CW-1:0] ALU_BNE  = 4'd10;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register: EX/MEM beats MEM/WB beats register file.
// FWD_EN=0 collapses the mux to a plain register-file pass-through.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW     = CPU_DW,
  parameter int AW     = CPU_AW,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [AW-1:0] idx_i,
  input  logic [DW-1:0] rf_data_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_result_i,
  output fwd_sel_t      sel_o,
  output logic [DW-1:0] data_o
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  // Register 0 is hard-wired to zero, so a write to it is never a forwarding source.
  assign w_exmem_hit = FWD_EN && exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == idx_i);
  assign w_memwb_hit = FWD_EN && memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == idx_i);

  always_comb begin
    sel_o  = FWD_RF;
    data_o = rf_data_i;
    if (w_exmem_hit) begin
      sel_o  = FWD_EXMEM;
      data_o = exmem_result_i;
    end else if (w_memwb_hit) begin
      sel_o  = FWD_MEMWB;
      data_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand select, EX/MEM + MEM/WB forwarding and load-use detection.
// Define ID_EX_FWD_EN to enable forwarding; without it the hazard widens to every RAW dependence.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW = CPU_DW,
  parameter int AW = CPU_AW,
  parameter int CW = CPU_CW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [15:0]   imm_i,
  input  logic          sign_ext_i,
  input  logic          alu_src_i,
  input  logic [CW-1:0] alu_ctrl_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          reg_dst_i,
  input  logic          reg_write_i,
  input  logic          mem_read_i,
  input  logic [AW-1:0] id_rs_addr_i,
  input  logic [AW-1:0] id_rt_addr_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_result_i,
  output logic [DW-1:0] src1_o,
  output logic [DW-1:0] src2_o,
  output logic [CW-1:0] ctrl_o,
  output logic [DW-1:0] store_data_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          reg_write_o,
  output logic          mem_read_o,
  output logic          valid_o,
  output logic          hazard_o,
  output fwd_sel_t      fwd_rs_sel_o,
  output fwd_sel_t      fwd_rt_sel_o
);

`ifdef ID_EX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic          r_valid;
  logic          r_reg_write;
  logic          r_mem_read;
  logic          r_alu_src;
  logic [CW-1:0] r_ctrl;
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_rs_addr;
  logic [AW-1:0] r_rt_addr;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [DW-1:0] r_imm_ext;

  logic [DW-1:0] w_imm_ext;
  logic [DW-1:0] w_rs_fwd;
  logic [DW-1:0] w_rt_fwd;
  logic          w_haz_src;
  logic          w_haz_match;

  assign w_imm_ext = {{(DW-16){imm_i[15] & sign_ext_i}}, imm_i};

  // Stage control: flush loads a bubble and wins over stall; stall holds everything;
  // otherwise the decode stage is captured and its side effects qualified by in_valid_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_alu_src   <= 1'b0;
      r_ctrl      <= '0;
      r_wr_addr   <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm_ext   <= '0;
    end else if (flush_i) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_alu_src   <= 1'b0;
      r_ctrl      <= '0;
      r_wr_addr   <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm_ext   <= '0;
    end else if (!stall_i) begin
      r_valid     <= in_valid_i;
      r_reg_write <= reg_write_i & in_valid_i;
      r_mem_read  <= mem_read_i & in_valid_i;
      r_alu_src   <= alu_src_i;
      r_ctrl      <= alu_ctrl_i;
      r_wr_addr   <= reg_dst_i ? rd_addr_i : rt_addr_i;
      r_rs_addr   <= rs_addr_i;
      r_rt_addr   <= rt_addr_i;
      r_rs_data   <= rs_data_i;
      r_rt_data   <= rt_data_i;
      r_imm_ext   <= w_imm_ext;
    end
  end

  fwd_mux #(.DW(DW), .AW(AW), .FWD_EN(FWD_EN)) u_fwd_rs (
    .idx_i             (r_rs_addr),
    .rf_data_i         (r_rs_data),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_result_i    (memwb_result_i),
    .sel_o             (fwd_rs_sel_o),
    .data_o            (w_rs_fwd)
  );

  fwd_mux #(.DW(DW), .AW(AW), .FWD_EN(FWD_EN)) u_fwd_rt (
    .idx_i             (r_rt_addr),
    .rf_data_i         (r_rt_data),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_result_i    (memwb_result_i),
    .sel_o             (fwd_rt_sel_o),
    .data_o            (w_rt_fwd)
  );

  assign src1_o       = w_rs_fwd;
  assign store_data_o = w_rt_fwd;
  assign src2_o       = r_alu_src ? r_imm_ext : w_rt_fwd;
  assign ctrl_o       = r_ctrl;
  assign wr_addr_o    = r_wr_addr;
  assign reg_write_o  = r_reg_write;
  assign mem_read_o   = r_mem_read;
  assign valid_o      = r_valid;

  // With forwarding only a load result arrives too late; without it any pending write does.
`ifdef ID_EX_FWD_EN
  assign w_haz_src = r_mem_read;
`else
  assign w_haz_src = r_reg_write;
`endif

  assign w_haz_match = (r_wr_addr == id_rs_addr_i) || (r_wr_addr == id_rt_addr_i);
  assign hazard_o    = r_valid && w_haz_src && (r_wr_addr != '0) && w_haz_match;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: reset, vector table, hand sequences, randomized model check.
// Expectations follow ID_EX_FWD_EN the same way the design does.
module tb_id_ex_operand_stage;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i, stall_i, flush_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic [15:0] imm_i;
  logic        sign_ext_i, alu_src_i;
  logic [3:0]  alu_ctrl_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic        reg_dst_i, reg_write_i, mem_read_i;
  logic [4:0]  id_rs_addr_i, id_rt_addr_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_result_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_result_i;
  logic [31:0] src1_o, src2_o, store_data_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  wr_addr_o;
  logic        reg_write_o, mem_read_o, valid_o, hazard_o;
  fwd_sel_t    fwd_rs_sel_o, fwd_rt_sel_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  id_ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .sign_ext_i(sign_ext_i),
    .alu_src_i(alu_src_i), .alu_ctrl_i(alu_ctrl_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rd_addr_i(rd_addr_i), .reg_dst_i(reg_dst_i), .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
    .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o), .store_data_o(store_data_o),
    .wr_addr_o(wr_addr_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .valid_o(valid_o), .hazard_o(hazard_o), .fwd_rs_sel_o(fwd_rs_sel_o), .fwd_rt_sel_o(fwd_rt_sel_o)
  );

  // Reference model: the instruction the stage is believed to hold.
  typedef struct {
    bit          valid, writes, loads, use_imm;
    bit [3:0]    op;
    bit [4:0]    dest, rs, rt;
    bit [31:0]   rs_val, rt_val, imm_val;
  } instr_t;

  instr_t held;

`ifdef ID_EX_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: '0};
    return b;
  endfunction

  function automatic instr_t next_instr(instr_t cur);
    instr_t n;
    if (flush_i) return bubble();
    if (stall_i) return cur;
    n.valid   = in_valid_i;
    n.writes  = in_valid_i && reg_write_i;
    n.loads   = in_valid_i && mem_read_i;
    n.use_imm = alu_src_i;
    n.op      = alu_ctrl_i;
    n.dest    = reg_dst_i ? rd_addr_i : rt_addr_i;
    n.rs      = rs_addr_i;
    n.rt      = rt_addr_i;
    n.rs_val  = rs_data_i;
    n.rt_val  = rt_data_i;
    n.imm_val = sign_ext_i ? 32'(int'($signed(imm_i))) : 32'(int'(imm_i));
    return n;
  endfunction

  // Value the ALU should see for register r whose file value was v.
  function automatic bit [31:0] operand(bit [4:0] r, bit [31:0] v);
    if (FWD_ON && r != 0 && exmem_reg_write_i && exmem_rd_i == r) return exmem_result_i;
    if (FWD_ON && r != 0 && memwb_reg_write_i && memwb_rd_i == r) return memwb_result_i;
    return v;
  endfunction

  function automatic bit exp_hazard(instr_t h);
    bit pending;
    pending = FWD_ON ? h.loads : h.writes;
    return h.valid && pending && h.dest != 0 && (h.dest == id_rs_addr_i || h.dest == id_rt_addr_i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    bit [31:0] rt_fwd;
    rt_fwd = operand(held.rt, held.rt_val);
    chk({tag, " src1"},  src1_o, operand(held.rs, held.rs_val));
    chk({tag, " store"}, store_data_o, rt_fwd);
    chk({tag, " src2"},  src2_o, held.use_imm ? held.imm_val : rt_fwd);
    chk({tag, " ctrl"},  32'(ctrl_o), 32'(held.op));
    chk({tag, " wr"},    32'(wr_addr_o), 32'(held.dest));
    chk({tag, " valid"}, 32'(valid_o), 32'(held.valid));
    chk({tag, " rw"},    32'(reg_write_o), 32'(held.writes));
    chk({tag, " mr"},    32'(mem_read_o), 32'(held.loads));
    chk({tag, " haz"},   32'(hazard_o), 32'(exp_hazard(held)));
  endtask

  task automatic tick();
    instr_t n;
    n = next_instr(held);
    @(posedge clk_i);
    #1;
    held = n;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write_i = ew; exmem_rd_i = erd; exmem_result_i = eres;
    memwb_reg_write_i = mw; memwb_rd_i = mrd; memwb_result_i = mres;
  endtask

  task automatic clear_dec();
    in_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    rs_data_i = '0; rt_data_i = '0; imm_i = '0; sign_ext_i = 1'b0; alu_src_i = 1'b0;
    alu_ctrl_i = '0; rs_addr_i = '0; rt_addr_i = '0; rd_addr_i = '0; reg_dst_i = 1'b0;
    reg_write_i = 1'b0; mem_read_i = 1'b0; id_rs_addr_i = '0; id_rt_addr_i = '0;
  endtask

  typedef struct {
    logic [31:0] rs_d, rt_d;
    logic [15:0] imm;
    logic        sx, asrc, rdst;
    logic [3:0]  op;
    logic [4:0]  rt_a, rd_a;
    logic [31:0] e_src1, e_src2;
    logic [4:0]  e_wr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'd5,        32'd0,        16'hFFF0, 1'b1, 1'b1, 1'b1, ALU_ADD, 5'd4, 5'd9,  32'd5,        32'hFFFF_FFF0, 5'd9};
    vecs[1] = '{32'd5,        32'd0,        16'hFFF0, 1'b0, 1'b1, 1'b1, ALU_ORI, 5'd4, 5'd9,  32'd5,        32'h0000_FFF0, 5'd9};
    vecs[2] = '{32'hDEAD_0001, 32'h1234,    16'hFFFF, 1'b1, 1'b0, 1'b0, ALU_SUB, 5'd4, 5'd9,  32'hDEAD_0001, 32'h0000_1234, 5'd4};
    vecs[3] = '{32'd0,        32'd0,        16'h7FFF, 1'b1, 1'b1, 1'b0, ALU_SLT, 5'd17, 5'd2, 32'd0,        32'h0000_7FFF, 5'd17};
    vecs[4] = '{32'd1,        32'd0,        16'h8000, 1'b1, 1'b1, 1'b1, ALU_LUI, 5'd0, 5'd31, 32'd1,        32'hFFFF_8000, 5'd31};
    vecs[5] = '{32'hFFFF_FFFF, 32'hCAFE_F00D, 16'h8000, 1'b0, 1'b0, 1'b1, ALU_BNE, 5'd1, 5'd30, 32'hFFFF_FFFF, 32'hCAFE_F00D, 5'd30};

    // Reset
    rst_i = 1'b1;
    clear_dec();
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
    held = bubble();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst rw",    32'(reg_write_o), 32'd0);
    chk("rst mr",    32'(mem_read_o), 32'd0);
    chk("rst ctrl",  32'(ctrl_o), 32'd0);
    chk("rst wr",    32'(wr_addr_o), 32'd0);
    chk("rst src1",  src1_o, 32'd0);
    chk("rst src2",  src2_o, 32'd0);
    chk("rst store", store_data_o, 32'd0);
    rst_i = 1'b0;

    // Vector table: capture and operand select, no forwarding sources active
    for (int i = 0; i < 6; i++) begin
      clear_dec();
      in_valid_i = 1'b1; reg_write_i = 1'b1;
      rs_addr_i = 5'd3;
      rs_data_i = vecs[i].rs_d; rt_data_i = vecs[i].rt_d; imm_i = vecs[i].imm;
      sign_ext_i = vecs[i].sx; alu_src_i = vecs[i].asrc; reg_dst_i = vecs[i].rdst;
      alu_ctrl_i = vecs[i].op; rt_addr_i = vecs[i].rt_a; rd_addr_i = vecs[i].rd_a;
      tick();
      chk($sformatf("vec%0d src1", i), src1_o, vecs[i].e_src1);
      chk($sformatf("vec%0d src2", i), src2_o, vecs[i].e_src2);
      chk($sformatf("vec%0d store", i), store_data_o, vecs[i].rt_d);
      chk($sformatf("vec%0d wr", i), 32'(wr_addr_o), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d ctrl", i), 32'(ctrl_o), 32'(vecs[i].op));
      chk($sformatf("vec%0d valid", i), 32'(valid_o), 32'd1);
    end

    // Forwarding priority on rs=3
    clear_dec();
    in_valid_i = 1'b1; rs_addr_i = 5'd3; rs_data_i = 32'h11;
    tick();
    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    #1;
    chk("fwd both src1", src1_o, FWD_ON ? 32'hAA : 32'h11);
    chk("fwd both sel",  32'(fwd_rs_sel_o), FWD_ON ? 32'(FWD_EXMEM) : 32'(FWD_RF));
    exmem_reg_write_i = 1'b0;
    #1;
    chk("fwd memwb src1", src1_o, FWD_ON ? 32'hBB : 32'h11);
    chk("fwd memwb sel",  32'(fwd_rs_sel_o), FWD_ON ? 32'(FWD_MEMWB) : 32'(FWD_RF));
    memwb_reg_write_i = 1'b0;
    #1;
    chk("fwd none src1", src1_o, 32'h11);

    // Register 0 is never forwarded
    clear_dec();
    in_valid_i = 1'b1; rt_addr_i = 5'd0; rt_data_i = 32'd0; alu_src_i = 1'b0;
    tick();
    set_fwd(1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd9);
    #1;
    chk("r0 src2",  src2_o, 32'd0);
    chk("r0 store", store_data_o, 32'd0);
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

    // Load-use hazard
    clear_dec();
    in_valid_i = 1'b1; mem_read_i = 1'b1; reg_write_i = 1'b1; rt_addr_i = 5'd8;
    id_rs_addr_i = 5'd1; id_rt_addr_i = 5'd8;
    tick();
    chk("lu hazard", 32'(hazard_o), 32'd1);
    chk("lu mr", 32'(mem_read_o), 32'd1);
    rt_addr_i = 5'd0; id_rt_addr_i = 5'd0;
    tick();
    chk("lu r0 hazard", 32'(hazard_o), 32'd0);
    mem_read_i = 1'b0; rt_addr_i = 5'd8; id_rs_addr_i = 5'd8; id_rt_addr_i = 5'd2;
    tick();
    chk("raw alu hazard", 32'(hazard_o), FWD_ON ? 32'd0 : 32'd1);

    // in_valid=0 qualifies side effects
    clear_dec();
    reg_write_i = 1'b1; mem_read_i = 1'b1; rt_addr_i = 5'd5;
    tick();
    chk("inv valid", 32'(valid_o), 32'd0);
    chk("inv rw",    32'(reg_write_o), 32'd0);
    chk("inv mr",    32'(mem_read_o), 32'd0);

    // Stall holds, stall+flush bubbles
    clear_dec();
    in_valid_i = 1'b1; reg_write_i = 1'b1; rs_data_i = 32'h55; alu_ctrl_i = ALU_OR; rt_addr_i = 5'd6;
    tick();
    stall_i = 1'b1; rs_data_i = 32'h99; alu_ctrl_i = ALU_SLTU; in_valid_i = 1'b0; rt_addr_i = 5'd7;
    tick();
    chk("stall src1",  src1_o, 32'h55);
    chk("stall ctrl",  32'(ctrl_o), 32'(ALU_OR));
    chk("stall valid", 32'(valid_o), 32'd1);
    chk("stall wr",    32'(wr_addr_o), 32'd6);
    flush_i = 1'b1;
    tick();
    chk("flush valid", 32'(valid_o), 32'd0);
    chk("flush rw",    32'(reg_write_o), 32'd0);
    chk("flush ctrl",  32'(ctrl_o), 32'd0);
    chk("flush src1",  src1_o, 32'd0);

    // Asynchronous reset between edges
    clear_dec();
    in_valid_i = 1'b1; reg_write_i = 1'b1; mem_read_i = 1'b1; alu_ctrl_i = ALU_BEQ; rt_addr_i = 5'd12;
    tick();
    chk("pre-rst valid", 32'(valid_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst valid", 32'(valid_o), 32'd0);
    chk("arst rw",    32'(reg_write_o), 32'd0);
    chk("arst mr",    32'(mem_read_o), 32'd0);
    chk("arst ctrl",  32'(ctrl_o), 32'd0);
    rst_i = 1'b0;
    held = bubble();

    // Randomized run against the model
    for (int i = 0; i < 300; i++) begin
      in_valid_i   = ($urandom_range(0, 3) != 0);
      stall_i      = ($urandom_range(0, 7) == 0);
      flush_i      = ($urandom_range(0, 7) == 0);
      rs_data_i    = $urandom; rt_data_i = $urandom; imm_i = 16'($urandom);
      sign_ext_i   = 1'($urandom); alu_src_i = 1'($urandom);
      alu_ctrl_i   = 4'($urandom_range(0, 10));
      rs_addr_i    = 5'($urandom_range(0, 7)); rt_addr_i = 5'($urandom_range(0, 7));
      rd_addr_i    = 5'($urandom_range(0, 7)); reg_dst_i = 1'($urandom);
      reg_write_i  = 1'($urandom); mem_read_i = 1'($urandom);
      id_rs_addr_i = 5'($urandom_range(0, 7)); id_rt_addr_i = 5'($urandom_range(0, 7));
      set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      tick();
      check_model($sformatf("rnd%0d", i));
      set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      id_rs_addr_i = 5'($urandom_range(0, 7));
      #1;
      check_model($sformatf("rnd%0db", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
